boot_loader_ctrl: RTL and testbench
===================================

Name: boot_loader_ctrl

Overview:
Boot sequencer for the 5-stage core. Receives a byte stream (length header, then instruction words), writes words into Inst_mem through the shared address/write port, then releases the CPU reset. Owns the Inst_mem address mux between the loader and ifu's Inst_addr. Holds rst_n_cpu low during load, and on error or reload.

Parameters:
DEPTH, 256, Inst_mem depth in 32-bit words; maximum accepted word count
RELEASE_DLY, 2, clocks between last write (or checksum accept) and rst_n_cpu rising; 0 allowed

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
byte_valid  in  1  stream byte valid
byte_data  in  8  stream byte
byte_ready  out  1  loader accepts byte; transfer when byte_valid && byte_ready
reload  in  1  synchronous request to restart loading
Inst_addr  in  32  fetch address from ifu
mem_addr  out  32  address to Inst_mem (mux result)
mem_wdata  out  32  write word to Inst_mem Inst_i
mem_wr_en  out  1  write enable to Inst_mem
rst_n_cpu  out  1  active-low reset for ifu and pipeline registers, registered
busy  out  1  loader owns Inst_mem port
done  out  1  CPU released (state RUN)
err  out  1  load failed (state ERR)
word_cnt  out  16  words written so far

Behaviour:
- Async reset: state HDR0; rst_n_cpu=0, mem_wr_en=0, mem_wdata=0, word_cnt=0, done=0, err=0, busy=1. All internal counters cleared.
- States: HDR0, HDR1, DATA, WRITE, (CHK), DELAY, RUN, ERR.
- HDR0/HDR1: byte_ready=1; each accepted byte is stored as len[7:0] / len[15:8] (little-endian).
- After HDR1 accept: len==0 -> DELAY; len>DEPTH -> ERR; otherwise DATA.
- DATA: byte_ready=1; accepted bytes fill word lanes 0..3, little-endian (first byte = bits [7:0]). The 4th accept -> WRITE.
- WRITE: single cycle; mem_wr_en=1, byte_ready=0, mem_wdata=assembled word, mem_addr=word_cnt*4. word_cnt increments at the end of the cycle. Next state: DATA if word_cnt+1<len, else DELAY (CHK when BOOT_CHKSUM_EN is defined).
- mem_addr combinational: WRITE ? word_cnt*4 : Inst_addr. mem_wr_en is 0 in every state except WRITE.
- DELAY: counter loads RELEASE_DLY on entry and decrements each cycle. At 0 -> RUN. RELEASE_DLY=0 -> RUN on the next cycle.
- RUN: rst_n_cpu=1 (registered, rises on the edge entering RUN), done=1, busy=0, byte_ready=0. Bytes in RUN are ignored and not accepted.
- ERR: err=1, rst_n_cpu=0, byte_ready=0; held until reload or rst_n.
- reload=1 in any state: on the next edge go to HDR0, rst_n_cpu=0, word_cnt=0, err=0, done=0, partial word discarded. reload beats a byte transfer in the same cycle (byte_ready forced 0 while reload=1). Inst_mem contents are not cleared.
- A stalled stream (byte_valid=0) holds state indefinitely; there is no timeout.
- Reset mid-load: async return to HDR0, CPU held in reset; partially written memory is left as is.
- word_cnt wraps never: bounded by len<=DEPTH.

Optional Feature:
BOOT_CHKSUM_EN
- Defined: after the last WRITE, state CHK takes one byte (byte_ready=1). It is compared to the 8-bit modulo-256 sum of all payload bytes (header excluded). Match -> DELAY; mismatch -> ERR. The sum is cleared on reset and reload.
- Not defined: CHK state, sum logic and comparator are absent; the last WRITE goes directly to DELAY.

Test Plan:
- Stream 02 00 | 13 00 10 00 | 93 00 20 00 -> two WRITE pulses: addr 0x0 data 0x00100013, addr 0x4 data 0x00200093. rst_n_cpu rises RELEASE_DLY+1 clocks after the 2nd write; word_cnt=2, done=1.
- Header 00 00 -> no write; rst_n_cpu=1 after DELAY; mem_addr follows Inst_addr (drive 0x10, expect 0x10).
- Header 01 01 (len 257 > 256) -> err=1, rst_n_cpu stays 0, byte_ready=0. Then reload pulse -> HDR0, err=0.
- byte_valid toggled 1/0 every cycle with len 1, data AA BB CC DD -> single write 0xDDCCBBAA at addr 0. No write is lost or duplicated.
- reload asserted mid-DATA after 2 of 4 bytes, then full stream len 1, data 11 22 33 44 -> write 0x44332211 at addr 0; the partial bytes are discarded.
- BOOT_CHKSUM_EN: len 1, data 01 02 03 04, checksum 0A -> RUN. Checksum 0B -> ERR, rst_n_cpu=0.

Source files
------------

// File: rtl/boot_loader_ctrl.sv
// Boot sequencer: loads a length-prefixed byte stream into Inst_mem, then releases the CPU.
// Optional checksum byte after the payload when BOOT_CHKSUM_EN is defined.
module boot_loader_ctrl #(
    parameter int DEPTH       = 256,
    parameter int RELEASE_DLY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        reload,
    input  logic [31:0] Inst_addr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr_en,
    output logic        rst_n_cpu,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] word_cnt
);

    localparam int DW = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY + 1) : 1;

    typedef enum logic [2:0] {
        S_HDR0  = 3'd0,
        S_HDR1  = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
`ifdef BOOT_CHKSUM_EN
        S_CHK   = 3'd4,
`endif
        S_DELAY = 3'd5,
        S_RUN   = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [1:0]    lane_q, lane_d;
    logic [31:0]   word_q, word_d;
    logic [15:0]   word_cnt_q, word_cnt_d;
    logic [DW-1:0] dly_q, dly_d;
    logic          rst_n_cpu_q, rst_n_cpu_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
`ifdef BOOT_CHKSUM_EN
    logic [7:0]    sum_q, sum_d;
`endif

    logic          xfer;
    logic [15:0]   len_full;

    always_comb begin
        byte_ready = 1'b0;
        case (state_q)
            S_HDR0, S_HDR1, S_DATA: byte_ready = 1'b1;
`ifdef BOOT_CHKSUM_EN
            S_CHK:                  byte_ready = 1'b1;
`endif
            default:                byte_ready = 1'b0;
        endcase
        // reload wins over any byte offered in the same cycle
        if (reload) byte_ready = 1'b0;
    end

    assign xfer     = byte_valid && byte_ready;
    assign len_full = {byte_data, len_q[7:0]};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        lane_d     = lane_q;
        word_d     = word_q;
        word_cnt_d = word_cnt_q;
        dly_d      = dly_q;
`ifdef BOOT_CHKSUM_EN
        sum_d      = sum_q;
`endif
        if (reload) begin
            state_d    = S_HDR0;
            len_d      = '0;
            lane_d     = '0;
            word_d     = '0;
            word_cnt_d = '0;
            dly_d      = '0;
`ifdef BOOT_CHKSUM_EN
            sum_d      = '0;
`endif
        end else begin
            case (state_q)
                S_HDR0: begin
                    if (xfer) begin
                        len_d[7:0] = byte_data;
                        state_d    = S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (xfer) begin
                        len_d[15:8] = byte_data;
                        if (len_full == 16'd0) begin
                            state_d = S_DELAY;
                            dly_d   = DW'(RELEASE_DLY);
                        end else if ({1'b0, len_full} > 17'(DEPTH)) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        case (lane_q)
                            2'd0:    word_d[7:0]   = byte_data;
                            2'd1:    word_d[15:8]  = byte_data;
                            2'd2:    word_d[23:16] = byte_data;
                            default: word_d[31:24] = byte_data;
                        endcase
                        lane_d = lane_q + 2'd1;
`ifdef BOOT_CHKSUM_EN
                        sum_d  = sum_q + byte_data;
`endif
                        if (lane_q == 2'd3) state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    word_cnt_d = word_cnt_q + 16'd1;
                    if (({1'b0, word_cnt_q} + 17'd1) < {1'b0, len_q}) begin
                        state_d = S_DATA;
                    end else begin
`ifdef BOOT_CHKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DELAY;
                        dly_d   = DW'(RELEASE_DLY);
`endif
                    end
                end
`ifdef BOOT_CHKSUM_EN
                S_CHK: begin
                    if (xfer) begin
                        if (byte_data == sum_q) begin
                            state_d = S_DELAY;
                            dly_d   = DW'(RELEASE_DLY);
                        end else begin
                            state_d = S_ERR;
                        end
                    end
                end
`endif
                S_DELAY: begin
                    if (dly_q == '0) state_d = S_RUN;
                    else             dly_d   = dly_q - DW'(1);
                end
                default: state_d = state_q;
            endcase
        end
        // status outputs are registered from the next state
        rst_n_cpu_d = (state_d == S_RUN);
        done_d      = (state_d == S_RUN);
        err_d       = (state_d == S_ERR);
        busy_d      = (state_d != S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HDR0;
            len_q       <= '0;
            lane_q      <= '0;
            word_q      <= '0;
            word_cnt_q  <= '0;
            dly_q       <= '0;
            rst_n_cpu_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
`ifdef BOOT_CHKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            lane_q      <= lane_d;
            word_q      <= word_d;
            word_cnt_q  <= word_cnt_d;
            dly_q       <= dly_d;
            rst_n_cpu_q <= rst_n_cpu_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
`ifdef BOOT_CHKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign mem_wr_en = (state_q == S_WRITE);
    assign mem_addr  = mem_wr_en ? {14'd0, word_cnt_q, 2'b00} : Inst_addr;
    assign mem_wdata = word_q;
    assign rst_n_cpu = rst_n_cpu_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Bench for boot_loader_ctrl: table of streams plus hand sequences, write scoreboard.
// Checksum cases are built in when BOOT_CHKSUM_EN is defined.
module tb_boot_loader_ctrl;

    localparam int DLY = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        reload;
    logic [31:0] Inst_addr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr_en;
    logic        rst_n_cpu;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] word_cnt;

    boot_loader_ctrl #(.DEPTH(256), .RELEASE_DLY(DLY)) dut (
        .clk(clk), .rst_n(rst_n),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .reload(reload), .Inst_addr(Inst_addr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
        .rst_n_cpu(rst_n_cpu), .busy(busy), .done(done), .err(err),
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_wr_cyc = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;
    logic [7:0]  sum;

    typedef struct {
        logic [95:0] bytes;
        int          n;
        int          gap;
        logic        exp_err;
        logic [15:0] exp_wc;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t vecs[4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_wr_en === 1'b1) begin
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %h data %h want none", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", mem_addr, mon_e[63:32]);
                chk("wr_data", mem_wdata, mon_e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        #1;
        while (byte_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (byte_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL byte_timeout: got byte_ready %b want 1", byte_ready);
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic pulse_reload(input logic with_byte);
        @(negedge clk);
        reload = 1'b1;
        if (with_byte) begin
            byte_valid = 1'b1;
            byte_data  = 8'h55;
        end
        #1;
        chk("reload_blocks_ready", byte_ready, 0);
        @(negedge clk);
        reload     = 1'b0;
        byte_valid = 1'b0;
        #1;
        chk("reload_err", err, 0);
        chk("reload_done", done, 0);
        chk("reload_rst_cpu", rst_n_cpu, 0);
        chk("reload_wc", word_cnt, 0);
        chk("reload_busy", busy, 1);
    endtask

    task automatic wait_release();
        int t;
        t = 0;
        while (rst_n_cpu !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("release_seen", rst_n_cpu, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{96'h0020_0093_0010_0013_0002, 10, 0, 1'b0, 16'd2, 2,
                    32'h0010_0013, 32'h0020_0093};
        vecs[1] = '{96'h0000, 2, 0, 1'b0, 16'd0, 0, 32'h0, 32'h0};
        vecs[2] = '{96'h0101, 2, 0, 1'b1, 16'd0, 0, 32'h0, 32'h0};
        vecs[3] = '{96'hDDCC_BBAA_0001, 6, 1, 1'b0, 16'd1, 1,
                    32'hDDCC_BBAA, 32'h0};

        rst_n      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        reload     = 1'b0;
        Inst_addr  = 32'h40;
        #12;
        chk("rst_rst_cpu", rst_n_cpu, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_wc", word_cnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 1);
        chk("rst_ready", byte_ready, 1);
        chk("rst_addr_mux", mem_addr, 32'h40);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            pulse_reload(1'b0);
            for (int w = 0; w < vecs[i].nw; w++)
                exp_q.push_back({32'(w * 4), (w == 0) ? vecs[i].w0 : vecs[i].w1});
            sum = 8'h00;
            for (int k = 0; k < vecs[i].n; k++) begin
                if (k >= 2) sum = sum + vecs[i].bytes[8*k +: 8];
                send_byte(vecs[i].bytes[8*k +: 8], vecs[i].gap);
            end
`ifdef BOOT_CHKSUM_EN
            if (vecs[i].nw > 0) send_byte(sum, 0);
`endif
            if (vecs[i].exp_err) begin
                repeat (3) @(negedge clk);
                #1;
                chk("err_flag", err, 1);
                chk("err_rst_cpu", rst_n_cpu, 0);
                chk("err_ready", byte_ready, 0);
            end else begin
                wait_release();
                chk("run_done", done, 1);
                chk("run_busy", busy, 0);
                chk("run_wc", word_cnt, vecs[i].exp_wc);
                chk("run_no_lost_write", exp_q.size(), 0);
`ifndef BOOT_CHKSUM_EN
                if (vecs[i].nw > 0)
                    chk("release_dly", cyc - last_wr_cyc, DLY + 2);
`endif
                Inst_addr = 32'h10 + 32'(i * 4);
                #1;
                chk("run_addr_mux", mem_addr, 32'h10 + 32'(i * 4));
            end
        end

        // bytes offered while running are never taken
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = 8'hEE;
        repeat (3) begin
            #1;
            chk("run_ignores_ready", byte_ready, 0);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        #1;
        chk("run_ignores_done", done, 1);
        chk("run_ignores_wc", word_cnt, 1);

        // len == DEPTH is accepted
        pulse_reload(1'b0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        chk("depth_len_err", err, 0);
        chk("depth_len_ready", byte_ready, 1);

        // reload mid-word discards the partial bytes
        pulse_reload(1'b0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        pulse_reload(1'b1);
        exp_q.push_back({32'h0, 32'h4433_2211});
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
`ifdef BOOT_CHKSUM_EN
        send_byte(8'hAA, 0);
`endif
        wait_release();
        chk("reload_seq_wc", word_cnt, 1);
        chk("reload_seq_q", exp_q.size(), 0);

`ifdef BOOT_CHKSUM_EN
        pulse_reload(1'b0);
        exp_q.push_back({32'h0, 32'h0403_0201});
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        send_byte(8'h0A, 0);
        wait_release();
        chk("chk_good_done", done, 1);
        pulse_reload(1'b0);
        exp_q.push_back({32'h0, 32'h0403_0201});
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        send_byte(8'h0B, 0);
        repeat (5) @(negedge clk);
        #1;
        chk("chk_bad_err", err, 1);
        chk("chk_bad_rst_cpu", rst_n_cpu, 0);
`endif

        repeat (4) @(negedge clk);
        chk("final_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
